// File: rtl/enc_pkg.sv
// Shared types and default widths for the encoder capture sequencer.
package enc_pkg;

  localparam int unsigned ENC_W  = 32;
  localparam int unsigned ENC_PW = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ARM,
    ZERO
  } enc_state_t;

endpackage

// File: rtl/sync_rise.sv
// N-flop synchronizer for an asynchronous pin followed by a registered
// rising-edge pulse (one clk wide).
module sync_rise #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [N-1:0] sync_q;
  logic         last_q;
  logic         rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      last_q <= sync_q[N-1];
      rise_q <= sync_q[N-1] & ~last_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/enc_capture_ctrl.sv
// Encoder sequencer: index homing (synchronous counter clear) plus periodic
// position/velocity snapshots handed out over valid/ready.
module enc_capture_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned W  = ENC_W,
  parameter int unsigned PW = ENC_PW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic          home_arm,
  input  logic          index,
  input  logic [W-1:0]  count,
  output logic          enc_clr_n,
  output logic          homed,
  output logic [W-1:0]  snap_pos,
  output logic [W-1:0]  snap_vel,
  output logic          snap_valid,
  input  logic          snap_ready,
  output logic          overrun,
  input  logic          clr_overrun
);

  enc_state_t    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [W-1:0]  vel_q, vel_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          homed_q, homed_d;
  logic          clr_n_q, clr_n_d;
  logic          index_rise;
  logic          tick;

  sync_rise #(.N(2)) u_index_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (index),
    .rise_o (index_rise)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      prev_q    <= '0;
      pos_q     <= '0;
      vel_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      homed_q   <= 1'b0;
      clr_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      prev_q    <= prev_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      homed_q   <= homed_d;
      clr_n_q   <= clr_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (home_arm) state_d = ARM;
        ARM:     if (index_rise) state_d = ZERO;
        ZERO:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear output is registered from the next state so it cannot glitch
  // while the state encoding switches.
  always_comb begin
    presc_d   = presc_q;
    prev_d    = prev_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    homed_d   = homed_q;
    clr_n_d   = (state_d != ZERO);
    tick      = 1'b0;

    if (state_q == ZERO || (state_q == IDLE && state_d == RUN)) begin
      presc_d = period - PW'(1);
    end else if ((state_q == RUN || state_q == ARM) && period != '0) begin
      if (presc_q == '0) begin
        tick    = 1'b1;
        presc_d = period - PW'(1);
      end else begin
        presc_d = presc_q - PW'(1);
      end
    end

    if (state_q == RUN && state_d == ARM) homed_d = 1'b0;
    else if (state_q == ZERO)             homed_d = 1'b1;

    if (clr_overrun) overrun_d = 1'b0;

    // prev advances on every tick, even a dropped one, so each velocity
    // always covers exactly one period.
    if (state_q == ZERO) begin
      prev_d = '0;
    end else if (tick) begin
      prev_d = count;
    end

    if (tick) begin
      if (!valid_q || snap_ready) begin
        pos_d   = count;
        vel_d   = count - prev_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && snap_ready) begin
      valid_d = 1'b0;
    end
  end

  assign enc_clr_n  = clr_n_q;
  assign homed      = homed_q;
  assign snap_pos   = pos_q;
  assign snap_vel   = vel_q;
  assign snap_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_enc_capture_ctrl.sv
// Directed bench for enc_capture_ctrl: table of ramp/period cases plus
// hand-written homing, overrun, period=0 and reset sequences.
module tb_enc_capture_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          enable, home_arm, index, snap_ready, clr_overrun;
  logic [PW-1:0] period;
  logic [W-1:0]  count;
  logic          enc_clr_n, homed, snap_valid, overrun;
  logic [W-1:0]  snap_pos, snap_vel;

  enc_capture_ctrl #(.W(W), .PW(PW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .period      (period),
    .home_arm    (home_arm),
    .index       (index),
    .count       (count),
    .enc_clr_n   (enc_clr_n),
    .homed       (homed),
    .snap_pos    (snap_pos),
    .snap_vel    (snap_vel),
    .snap_valid  (snap_valid),
    .snap_ready  (snap_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          j;
  logic [W-1:0] step;
  logic        clr_seen;

  typedef struct {
    logic [PW-1:0] period;
    logic [W-1:0]  step;
    logic [W-1:0]  start;
    logic [W-1:0]  pos1;
    logic [W-1:0]  vel1;
    logic [W-1:0]  pos2;
    logic [W-1:0]  vel2;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs change 1ns after the edge; the bench plays the
  // encoder counter, which clears on the edge after enc_clr_n is seen low.
  task automatic tick1();
    @(posedge clk);
    #1;
    j++;
    if (clr_seen) count = '0;
    else          count = count + step;
    clr_seen = !enc_clr_n;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_clr_n"},   32'(enc_clr_n),  32'd1);
    chk({tag, "_homed"},   32'(homed),      32'd0);
    chk({tag, "_pos"},     snap_pos,        32'd0);
    chk({tag, "_vel"},     snap_vel,        32'd0);
    chk({tag, "_valid"},   32'(snap_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun),    32'd0);
  endtask

  task automatic do_reset();
    enable = 1'b0; home_arm = 1'b0; index = 1'b0; snap_ready = 1'b0;
    clr_overrun = 1'b0; period = '0; count = '0; step = '0; clr_seen = 1'b0;
    resetn = 1'b0;
    #1;
    chk_reset("rst");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    j = 0;
  endtask

  task automatic start_run(input logic [PW-1:0] p, input logic [W-1:0] s, input logic [W-1:0] st);
    period = p;
    step   = s;
    count  = st;
    enable = 1'b1;
    j      = 0;
  endtask

  task automatic run_home();
    int lows, first, got;
    home_arm = 1'b1;
    tick1();
    home_arm = 1'b0;
    tick1();
    index = 1'b1;
    lows = 0; first = -1; got = -1;
    for (int o = 1; o <= 14; o++) begin
      tick1();
      if (o == 5) index = 1'b0;
      if (!enc_clr_n) begin
        lows++;
        if (first < 0) first = o;
      end
      if (o == 4) chk("homed_before_zero", 32'(homed), 32'd0);
      if (o == 5) chk("homed_after_zero", 32'(homed), 32'd1);
      if (o >= 6 && snap_valid && got < 0) begin
        got = o;
        chk("home_pos", snap_pos, 32'd9);
        chk("home_vel", snap_vel, 32'd9);
      end
    end
    chk("clr_low_cycles", 32'(lows), 32'd1);
    chk("clr_low_offset", 32'(first), 32'd4);
    chk("home_snap_offset", 32'(got), 32'd9);
  endtask

  initial begin
    int n, lows, nv;

    tbl[0] = '{period: 16'd4, step: 32'd3,          start: 32'd0,
               pos1: 32'd12,         vel1: 32'd12,         pos2: 32'd24,         vel2: 32'd12};
    tbl[1] = '{period: 16'd4, step: 32'd8,          start: 32'h7FFF_FFD0,
               pos1: 32'h7FFF_FFF0, vel1: 32'h7FFF_FFF0, pos2: 32'h8000_0010, vel2: 32'h0000_0020};
    tbl[2] = '{period: 16'd3, step: 32'hFFFF_FFFB,  start: 32'd100,
               pos1: 32'd85,         vel1: 32'd85,         pos2: 32'd70,         vel2: 32'hFFFF_FFF1};
    tbl[3] = '{period: 16'd2, step: 32'd7,          start: 32'd0,
               pos1: 32'd14,         vel1: 32'd14,         pos2: 32'd28,         vel2: 32'd14};

    #2;

    for (int r = 0; r < 4; r++) begin
      do_reset();
      snap_ready = 1'b1;
      start_run(tbl[r].period, tbl[r].step, tbl[r].start);
      n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
        tick1();
        if (snap_valid) begin
          n++;
          if (n == 1) begin
            chk("first_tick_cycle", 32'(j), 32'(tbl[r].period) + 32'd1);
            chk("pos1", snap_pos, tbl[r].pos1);
            chk("vel1", snap_vel, tbl[r].vel1);
          end else begin
            chk("second_tick_cycle", 32'(j), 32'd2 * 32'(tbl[r].period) + 32'd1);
            chk("pos2", snap_pos, tbl[r].pos2);
            chk("vel2", snap_vel, tbl[r].vel2);
          end
          tick1();
          chk("valid_drop_after_accept", 32'(snap_valid), 32'd0);
        end
      end
      chk("table_snapshots_seen", 32'(n), 32'd2);
    end

    // Homing, unarmed index pulses, re-arm, second homing
    do_reset();
    snap_ready = 1'b1;
    start_run(16'd4, 32'd3, 32'd1000);
    repeat (10) tick1();
    chk("homed_initial", 32'(homed), 32'd0);
    run_home();

    lows = 0;
    for (int p = 0; p < 2; p++) begin
      index = 1'b1;
      repeat (2) begin tick1(); if (!enc_clr_n) lows++; end
      index = 1'b0;
      repeat (5) begin tick1(); if (!enc_clr_n) lows++; end
    end
    chk("unarmed_index_clr", 32'(lows), 32'd0);
    chk("unarmed_index_homed", 32'(homed), 32'd1);

    home_arm = 1'b1;
    tick1();
    home_arm = 1'b0;
    tick1();
    chk("rearm_clears_homed", 32'(homed), 32'd0);
    run_home();

    // Reset with homed=1 and a pending snapshot
    snap_ready = 1'b0;
    repeat (6) tick1();
    chk("pending_before_reset", 32'(snap_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset("async_rst_run");
    @(posedge clk);
    #1;
    resetn = 1'b1;
    snap_ready = 1'b1;
    start_run(16'd4, 32'd3, 32'd0);
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      tick1();
      if (snap_valid) begin
        n = 1;
        chk("rerun_tick_cycle", 32'(j), 32'd5);
        chk("rerun_homed", 32'(homed), 32'd0);
      end
    end
    chk("rerun_snapshot_seen", 32'(n), 32'd1);

    // Overrun: consumer stalls across three ticks
    do_reset();
    start_run(16'd4, 32'd3, 32'd0);
    repeat (8) tick1();
    chk("ovr_first_valid", 32'(snap_valid), 32'd1);
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    repeat (5) tick1();
    chk("ovr_held_pos", snap_pos, 32'd12);
    chk("ovr_held_vel", snap_vel, 32'd12);
    chk("ovr_set", 32'(overrun), 32'd1);
    snap_ready = 1'b1;
    tick1();
    chk("ovr_accept_drop", 32'(snap_valid), 32'd0);
    repeat (3) tick1();
    chk("ovr_next_valid", 32'(snap_valid), 32'd1);
    chk("ovr_next_pos", snap_pos, 32'd48);
    chk("ovr_next_vel", snap_vel, 32'd12);
    snap_ready = 1'b0;
    clr_overrun = 1'b1;
    tick1();
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    chk("ovr_held_valid", 32'(snap_valid), 32'd1);
    repeat (2) tick1();
    clr_overrun = 1'b1;
    tick1();
    clr_overrun = 1'b0;
    chk("ovr_set_beats_clear", 32'(overrun), 32'd1);
    chk("ovr_pos_still_held", snap_pos, 32'd48);

    // Reset asserted while armed with a snapshot pending
    home_arm = 1'b1;
    tick1();
    home_arm = 1'b0;
    index = 1'b1;
    repeat (2) tick1();
    #2;
    resetn = 1'b0;
    #1;
    chk_reset("async_rst_arm");
    index = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // period = 0 disables sampling
    do_reset();
    snap_ready = 1'b1;
    start_run(16'd0, 32'd1, 32'd0);
    nv = 0;
    repeat (100) begin
      tick1();
      if (snap_valid) nv++;
    end
    chk("period0_no_valid", 32'(nv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
